// File: rtl/ram_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl_if
// One valid/ready stream with a data payload. ram_fifo_ctrl uses one instance
// for its write side and a second one for its read side.
//
// Signals:
//   valid : producer has a word on data
//   ready : consumer can take the word this cycle
//   data  : payload, WIDTH bits
//
// Modports:
//   master : drives valid/data, samples ready (the producing end)
//   slave  : samples valid/data, drives ready (the consuming end)
// ---------------------------------------------------------------------------
interface ram_fifo_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
// Turns a simple dual-port RAM with a registered read (1-cycle read latency)
// into a streaming FIFO. The controller owns both RAM addresses, the write
// enable and the write data. A 2-entry output buffer hides the read latency,
// so both sides sustain one word per cycle once primed.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   flush             : synchronous clear of all contents
//   s_if (slave)      : write stream  (s_valid / s_ready / s_data)
//   m_if (master)     : read stream   (m_valid / m_ready / m_data)
//   level             : entries held (RAM + in-flight read + output buffer)
//   ram_write_address : RAM write address (write pointer)
//   ram_read_address  : RAM read address (read pointer)
//   ram_input_data    : RAM write data
//   ram_write_enable  : RAM write enable
//   ram_output_data   : RAM read data, valid the cycle after the address
//   almost_full       : registered, level >= AF_THRESH (optional)
//
// Optional feature: define RAM_FIFO_ALMOST_FULL_EN to add the almost_full
// port, the AF_THRESH parameter and its comparator.
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10
`ifdef RAM_FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = 2**ADDR_BITS - 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    ram_fifo_ctrl_if.slave       s_if,
    ram_fifo_ctrl_if.master      m_if,
    output logic [ADDR_BITS+1:0] level,
    output logic [ADDR_BITS-1:0] ram_write_address,
    output logic [ADDR_BITS-1:0] ram_read_address,
    output logic [WIDTH-1:0]     ram_input_data,
    output logic                 ram_write_enable,
    input  logic [WIDTH-1:0]     ram_output_data
`ifdef RAM_FIFO_ALMOST_FULL_EN
    ,
    output logic                 almost_full
`endif
);

    localparam int DEPTH = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

    logic [ADDR_BITS-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_BITS-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_BITS:0]   ram_count, ram_count_nxt;
    logic                 rd_pending, rd_pending_nxt;
    logic [1:0]           buf_count, buf_count_nxt;
    logic [WIDTH-1:0]     buf0, buf0_nxt;
    logic [WIDTH-1:0]     buf1, buf1_nxt;
    logic                 alive;
    logic                 accept;
    logic                 pop;
    logic                 issue;
    logic [1:0]           slots;

    // alive keeps s_ready low through reset and up to the first clock edge
    // after release.
    assign s_if.ready = alive & (ram_count != FULL_COUNT) & ~flush;
    assign accept     = s_if.valid & s_if.ready;

    // buf0 is always the head of the output buffer.
    assign m_if.valid = (buf_count != 2'd0);
    assign m_if.data  = buf0;
    assign pop        = m_if.valid & m_if.ready;

    // Output-side slots still claimed after this cycle: buffered words plus
    // the read in flight, minus the word leaving now. A read may only be
    // issued if its data will have somewhere to land.
    assign slots = buf_count + {1'b0, rd_pending} - {1'b0, pop};
    assign issue = ~flush & (ram_count != '0) & (slots < 2'd2);

    assign ram_write_enable  = accept;
    assign ram_input_data    = s_if.data;
    assign ram_write_address = wr_ptr;
    assign ram_read_address  = rd_ptr;

    assign level = (ADDR_BITS+2)'(ram_count) + (ADDR_BITS+2)'(rd_pending)
                 + (ADDR_BITS+2)'(buf_count);

    always_comb begin
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        ram_count_nxt  = ram_count;
        rd_pending_nxt = issue;
        buf_count_nxt  = buf_count;
        buf0_nxt       = buf0;
        buf1_nxt       = buf1;
        if (flush) begin
            wr_ptr_nxt     = '0;
            rd_ptr_nxt     = '0;
            ram_count_nxt  = '0;
            rd_pending_nxt = 1'b0;
            buf_count_nxt  = 2'd0;
            buf0_nxt       = '0;
            buf1_nxt       = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (accept) wr_ptr_nxt = wr_ptr + 1'b1;
            if (issue)  rd_ptr_nxt = rd_ptr + 1'b1;
            case ({accept, issue})
                2'b10:   ram_count_nxt = ram_count + 1'b1;
                2'b01:   ram_count_nxt = ram_count - 1'b1;
                default: ram_count_nxt = ram_count;
            endcase
            // Returning RAM data lands behind whatever stays in the buffer.
            case ({rd_pending, pop})
                2'b01: begin
                    buf0_nxt      = buf1;
                    buf_count_nxt = buf_count - 1'b1;
                end
                2'b10: begin
                    if (buf_count == 2'd0) buf0_nxt = ram_output_data;
                    else                   buf1_nxt = ram_output_data;
                    buf_count_nxt = buf_count + 1'b1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf0_nxt = ram_output_data;
                    end else begin
                        buf0_nxt = buf1;
                        buf1_nxt = ram_output_data;
                    end
                end
                default: buf_count_nxt = buf_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            rd_pending <= 1'b0;
            buf_count  <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            alive      <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            ram_count  <= ram_count_nxt;
            rd_pending <= rd_pending_nxt;
            buf_count  <= buf_count_nxt;
            buf0       <= buf0_nxt;
            buf1       <= buf1_nxt;
            alive      <= 1'b1;
        end
    end

`ifdef RAM_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_BITS+1:0] AF_LEVEL = (ADDR_BITS+2)'(AF_THRESH);

    logic [ADDR_BITS+1:0] level_nxt;

    // Registered from the next-state level so it lines up with level.
    assign level_nxt = (ADDR_BITS+2)'(ram_count_nxt) + (ADDR_BITS+2)'(rd_pending_nxt)
                     + (ADDR_BITS+2)'(buf_count_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     almost_full <= 1'b0;
        else if (flush) almost_full <= 1'b0;
        else            almost_full <= (level_nxt >= AF_LEVEL);
    end
`endif

endmodule
